// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core's ID->EXE pipeline register.
//   exe_cmd_e    : ALU command encodings produced by the control unit
//   id_ctrl_t    : decoded control word carried from ID to EXE
//   CTRL_BUBBLE  : control word of an empty slot (no side effects)
//   edge_act_e   : what the stage register does on a clock edge
//   decide_action: strict-priority HOLD > KILL > BUBBLE > LOAD decision
package core_pkg;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_read_en;
        logic       mem_write_en;
        logic       wb_en;
        logic       b;
        logic       s;
    } id_ctrl_t;

    // An empty slot must not write the register file, write memory,
    // branch or update status, so every control bit is zero.
    localparam id_ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_KILL   = 2'd2,
        ACT_BUBBLE = 2'd3
    } edge_act_e;

    // Freeze outranks everything: the branch in EXE is stalled as well and
    // will reassert flush once the stall ends, so nothing is lost.
    function automatic edge_act_e decide_action(input logic freeze,
                                                input logic flush,
                                                input logic hazard);
        if (freeze)      return ACT_HOLD;
        else if (flush)  return ACT_KILL;
        else if (hazard) return ACT_BUBBLE;
        else             return ACT_LOAD;
    endfunction

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// ID->EXE bus: the *_in signals are driven by the ID stage, the *_out
// signals are the registered copies presented to the EXE stage.
//   master : ID side / environment (drives *_in, observes *_out)
//   slave  : the stage register (consumes *_in, drives *_out)
interface id_exe_stage_reg_if #(
    parameter int WORD_W = 32
);
    logic              valid_in,         valid_out;
    logic [3:0]        exe_cmd_in,       exe_cmd_out;
    logic              mem_read_en_in,   mem_read_en_out;
    logic              mem_write_en_in,  mem_write_en_out;
    logic              wb_en_in,         wb_en_out;
    logic              b_in,             b_out;
    logic              s_in,             s_out;
    logic [WORD_W-1:0] pc_in,            pc_out;
    logic [WORD_W-1:0] val_rn_in,        val_rn_out;
    logic [WORD_W-1:0] val_rm_in,        val_rm_out;
    logic              imm_in,           imm_out;
    logic [11:0]       shift_operand_in, shift_operand_out;
    logic [23:0]       signed_imm24_in,  signed_imm24_out;
    logic [3:0]        dest_in,          dest_out;
    logic [3:0]        src1_in,          src1_out;
    logic [3:0]        src2_in,          src2_out;
    logic              carry_in,         carry_out;

    modport master (
        output valid_in, exe_cmd_in, mem_read_en_in, mem_write_en_in, wb_en_in,
               b_in, s_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
               signed_imm24_in, dest_in, src1_in, src2_in, carry_in,
        input  valid_out, exe_cmd_out, mem_read_en_out, mem_write_en_out, wb_en_out,
               b_out, s_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
               signed_imm24_out, dest_out, src1_out, src2_out, carry_out
    );

    modport slave (
        input  valid_in, exe_cmd_in, mem_read_en_in, mem_write_en_in, wb_en_in,
               b_in, s_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
               signed_imm24_in, dest_in, src1_in, src2_in, carry_in,
        output valid_out, exe_cmd_out, mem_read_en_out, mem_write_en_out, wb_en_out,
               b_out, s_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
               signed_imm24_out, dest_out, src1_out, src2_out, carry_out
    );
endinterface

// File: rtl/id_exe_stage_reg_sat_counter.sv
// Saturating up-counter for pipeline event statistics.
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   inc_i      : count one event on this edge (ignored once all-ones)
//   clr_i      : synchronous clear, overrides inc_i
//   cnt_o      : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze, flush and bubble handling.
//   clk, rst_n           : clock, asynchronous active-low reset
//   freeze               : hold all state (memory stall)
//   flush                : kill the ID instruction (branch taken in EXE)
//   hazard               : insert a bubble (data hazard)
//   cnt_clr              : synchronous clear of both event counters
//   bus (slave)          : ID-side *_in fields, EXE-side registered *_out fields
//   flush_cnt/bubble_cnt : saturating counts of accepted flushes/bubbles
module id_exe_stage_reg
    import core_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             hazard,
    input  logic             cnt_clr,
    id_exe_stage_reg_if.slave bus,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    edge_act_e         act;
    logic              squash;
    id_ctrl_t          ctrl_in, ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [WORD_W-1:0] pc_d, pc_q, val_rn_d, val_rn_q, val_rm_d, val_rm_q;
    logic              imm_d, imm_q, carry_d, carry_q;
    logic [11:0]       shift_d, shift_q;
    logic [23:0]       simm_d, simm_q;
    logic [3:0]        dest_d, dest_q, src1_d, src1_q, src2_d, src2_q;

    // NOTE: every variable below is assigned on every path through the
    // block, so no latch can be inferred.
    always_comb begin
        act     = decide_action(freeze, flush, hazard);
        squash  = (act == ACT_KILL) || (act == ACT_BUBBLE);
        ctrl_in = '{exe_cmd:      bus.exe_cmd_in,
                    mem_read_en:  bus.mem_read_en_in,
                    mem_write_en: bus.mem_write_en_in,
                    wb_en:        bus.wb_en_in,
                    b:            bus.b_in,
                    s:            bus.s_in};
        // An invalid ID slot still loads its data but carries no side effects.
        ctrl_d   = (squash || !bus.valid_in) ? CTRL_BUBBLE : ctrl_in;
        valid_d  = !squash && bus.valid_in;
        pc_d     = squash ? '0 : bus.pc_in;
        val_rn_d = squash ? '0 : bus.val_rn_in;
        val_rm_d = squash ? '0 : bus.val_rm_in;
        imm_d    = squash ? 1'b0 : bus.imm_in;
        shift_d  = squash ? '0 : bus.shift_operand_in;
        simm_d   = squash ? '0 : bus.signed_imm24_in;
        dest_d   = squash ? '0 : bus.dest_in;
        src1_d   = squash ? '0 : bus.src1_in;
        src2_d   = squash ? '0 : bus.src2_in;
        carry_d  = squash ? 1'b0 : bus.carry_in;
    end

    // NOTE: every stage flop is reset (not just the control bits) so the
    // EXE stage never sees X data feeding forwarding muxes after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= CTRL_BUBBLE;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
            imm_q    <= 1'b0;
            shift_q  <= '0;
            simm_q   <= '0;
            dest_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            carry_q  <= 1'b0;
        end else if (act != ACT_HOLD) begin
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            val_rn_q <= val_rn_d;
            val_rm_q <= val_rm_d;
            imm_q    <= imm_d;
            shift_q  <= shift_d;
            simm_q   <= simm_d;
            dest_q   <= dest_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.valid_out         = valid_q;
    assign bus.exe_cmd_out       = ctrl_q.exe_cmd;
    assign bus.mem_read_en_out   = ctrl_q.mem_read_en;
    assign bus.mem_write_en_out  = ctrl_q.mem_write_en;
    assign bus.wb_en_out         = ctrl_q.wb_en;
    assign bus.b_out             = ctrl_q.b;
    assign bus.s_out             = ctrl_q.s;
    assign bus.pc_out            = pc_q;
    assign bus.val_rn_out        = val_rn_q;
    assign bus.val_rm_out        = val_rm_q;
    assign bus.imm_out           = imm_q;
    assign bus.shift_operand_out = shift_q;
    assign bus.signed_imm24_out  = simm_q;
    assign bus.dest_out          = dest_q;
    assign bus.src1_out          = src1_q;
    assign bus.src2_out          = src2_q;
    assign bus.carry_out         = carry_q;

    // Counters see only accepted events; a frozen edge neither counts nor clears.
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (act == ACT_KILL),
        .clr_i (!freeze && cnt_clr),
        .cnt_o (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (act == ACT_BUBBLE),
        .clr_i (!freeze && cnt_clr),
        .cnt_o (bubble_cnt)
    );
endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
ID→EXE pipeline register of the ARM-subset 5-stage core. It captures the decoded control word (exe_cmd, mem_read_en, mem_write_en, wb_en, B, S), the operands and the instruction fields produced in the ID stage, and presents them to the EXE stage one cycle later. It handles pipeline freeze (memory stall), branch flush and hazard bubble insertion. Saturating event counters for flushes and bubbles support performance debug.

Parameters:
WORD_W, 32, width of PC and register operand values
CNT_W, 16, width of the flush and bubble event counters

Ports:
clk  in  1  core clock, rising-edge
rst_n  in  1  asynchronous active-low reset
freeze  in  1  global stall; hold all state
flush  in  1  branch taken in EXE; kill the ID instruction
hazard  in  1  data hazard detected; insert a bubble
cnt_clr  in  1  synchronous clear of both counters
valid_in  in  1  ID holds a real instruction
exe_cmd_in  in  4  ALU command from control unit
mem_read_en_in, mem_write_en_in, wb_en_in, b_in, s_in  in  1 each  control bits from control unit
pc_in  in  WORD_W  PC+4 of the ID instruction
val_rn_in, val_rm_in  in  WORD_W  register file read values
imm_in  in  1  I bit
shift_operand_in  in  12  shifter operand field
signed_imm24_in  in  24  branch offset
dest_in, src1_in, src2_in  in  4 each  register numbers (src used by forwarding)
carry_in  in  1  status register C
valid_out, exe_cmd_out, mem_read_en_out, mem_write_en_out, wb_en_out, b_out, s_out  out  same widths  registered control
pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out, dest_out, src1_out, src2_out, carry_out  out  same widths  registered data
flush_cnt  out  CNT_W  accepted flushes
bubble_cnt  out  CNT_W  accepted bubbles

Behaviour:
- Reset (rst_n=0, asynchronous): every output, including both counters, goes to 0 immediately and holds until rst_n rises.
- Latency: 1 cycle. Inputs sampled on the rising edge appear on outputs after that edge.
- Per-edge action, strict priority:
  1. freeze=1: HOLD. All registers and counters keep their values, including when flush or hazard is also 1. The branch in EXE is also frozen, so it reasserts flush after the freeze.
  2. flush=1: KILL. valid_out, wb_en_out, mem_read_en_out, mem_write_en_out, b_out, s_out=0; exe_cmd_out=0; all data fields=0. flush_cnt+1.
  3. hazard=1: BUBBLE. Same zeroing as KILL. bubble_cnt+1.
  4. Otherwise: LOAD. All *_in go to *_out.
- In LOAD, if valid_in=0, the control bits and exe_cmd are forced to 0. Data fields load as normal.
- A bubble or killed slot must never write the register file, write memory, branch or update status.
- Counters:
  - Saturate at all-ones, with no wrap.
  - cnt_clr=1 zeroes both counters on the edge and overrides any increment on that edge.
  - cnt_clr is ignored during freeze.
- flush and hazard together: KILL wins; only flush_cnt increments.
- There is no state machine beyond the HOLD/KILL/BUBBLE/LOAD edge decision. Counters are the only multi-cycle state.

Decomposition:
- Shared package core_pkg holds:
  - exe_cmd encodings: MOV=0001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000, MVN=1001, NOP=0000.
  - an id_ctrl_t struct {exe_cmd, mem_read_en, mem_write_en, wb_en, b, s}.
  - the constant CTRL_BUBBLE (all zero).
- One sub-module is natural: sat_counter (CNT_W parameter; inc, clr inputs; async active-low reset). It is instantiated twice.

Test Plan:
- Reset: drive all inputs to 1, rst_n=0 mid-cycle → all outputs 0 without waiting for an edge; after release with no edge, outputs stay 0.
- Load: valid_in=1, exe_cmd_in=0010, wb_en_in=1, pc_in=0x0000_0010, val_rn_in=5, dest_in=3 → after 1 edge, outputs equal those values with valid_out=1; counters stay 0.
- Hazard: LOAD ADD, then one cycle hazard=1 with SUB on inputs → bubble cycle shows all control 0 and exe_cmd 0, bubble_cnt=1; next edge with hazard=0 loads SUB (exe_cmd_out=0100).
- Flush plus hazard: flush=1 and hazard=1 together with STR on inputs (mem_write_en_in=1) → mem_write_en_out=0, valid_out=0, flush_cnt=1, bubble_cnt=0.
- Freeze priority: registers hold MOV with wb_en_out=1; assert freeze=1 with flush=1 and cnt_clr=1 for 3 edges → outputs and counters unchanged; drop freeze while keeping flush → KILL occurs, and flush_cnt increments from its held value (cnt_clr released).
- Saturation: CNT_W=4, 17 consecutive flushes → flush_cnt=15 (stays at 15); one edge with cnt_clr=1 and flush=1 → flush_cnt=0.
